// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state type and
// well-known register/select constants.
package hazard_ctrl_unit_pkg;

   // Register x0 is hardwired to zero and never creates a dependency.
   localparam int unsigned REG_X0     = 0;
   // Forward select value meaning "take the operand from the register file".
   localparam int unsigned FWD_SEL_RF = 0;

   // Hazard class that won arbitration in the previous cycle.
   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LU_STALL = 2'd1,
      ST_SB_STALL = 2'd2,
      ST_MEM_WAIT = 2'd3
   } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_unit_scoreboard.sv
// Busy-bit scoreboard for long-latency writebacks. One bit per architectural
// register; x0 is never marked busy. Two source read ports and one WAW port.
module hazard_ctrl_unit_scoreboard
   import hazard_ctrl_unit_pkg::*;
#(
   parameter int unsigned REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              set_i,
   input  logic [REG_AW-1:0] set_rd_i,
   input  logic              clr_i,
   input  logic [REG_AW-1:0] clr_rd_i,
   input  logic [REG_AW-1:0] rd_a_i,
   input  logic [REG_AW-1:0] rd_b_i,
   input  logic [REG_AW-1:0] rd_w_i,
   output logic              busy_a_o,
   output logic              busy_b_o,
   output logic              busy_w_o
);

   localparam int unsigned NREG = 1 << REG_AW;

   logic [NREG-1:0] busy_q, busy_d;

   // Next busy vector: clear first so a same-register set in the same cycle wins.
   always_comb begin
      busy_d = busy_q;
      if (clr_i) busy_d[clr_rd_i] = 1'b0;
      if (set_i) busy_d[set_rd_i] = 1'b1;
      busy_d[REG_X0] = 1'b0;
   end

   // Busy vector register, emptied asynchronously by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   assign busy_a_o = busy_q[rd_a_i];
   assign busy_b_o = busy_q[rd_b_i];
   assign busy_w_o = busy_q[rd_w_i];

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the RV32I pipeline: priority operand forwarding,
// load-use and scoreboard stalls, data-memory freeze and redirect flushes.
module hazard_ctrl_unit
   import hazard_ctrl_unit_pkg::*;
#(
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned NUM_FWD = 2,
   parameter int unsigned SEL_W   = 2,
   parameter int unsigned CNT_W   = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_FWD-1:0]        fwd_valid,
   input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
   input  logic [REG_AW-1:0]         ex_rs1,
   input  logic [REG_AW-1:0]         ex_rs2,
   input  logic                      ex_mem_read,
   input  logic [REG_AW-1:0]         ex_rd,
   input  logic [REG_AW-1:0]         id_rs1,
   input  logic [REG_AW-1:0]         id_rs2,
   input  logic                      id_use_rs1,
   input  logic                      id_use_rs2,
   input  logic [REG_AW-1:0]         id_rd,
   input  logic                      id_reg_write,
   input  logic                      lat_issue,
   input  logic [REG_AW-1:0]         lat_rd,
   input  logic                      lat_done,
   input  logic [REG_AW-1:0]         lat_done_rd,
   input  logic                      mem_busy,
   input  logic                      ex_redirect,
   output logic [SEL_W-1:0]          forward_a,
   output logic [SEL_W-1:0]          forward_b,
   output logic                      stall_if,
   output logic                      stall_id,
   output logic                      stall_ex_mem_wb,
   output logic                      bubble_ex,
   output logic                      flush_if,
   output logic                      flush_id,
   output logic [CNT_W-1:0]          stall_cycles
);

   localparam logic [REG_AW-1:0] X0 = REG_AW'(REG_X0);

   // ---------------- Forwarding ----------------
   logic [NUM_FWD-1:0] hit_a, hit_b;
   logic [SEL_W-1:0]   sel_a, sel_b;

   for (genvar g = 0; g < NUM_FWD; g++) begin : g_src
      logic [REG_AW-1:0] src_rd;
      assign src_rd   = fwd_rd[g*REG_AW +: REG_AW];
      assign hit_a[g] = fwd_valid[g] && (src_rd != X0) && (src_rd == ex_rs1);
      assign hit_b[g] = fwd_valid[g] && (src_rd != X0) && (src_rd == ex_rs2);
   end

   // Priority pick: scan oldest to youngest so the youngest matching source wins.
   always_comb begin
      sel_a = SEL_W'(FWD_SEL_RF);
      sel_b = SEL_W'(FWD_SEL_RF);
      for (int unsigned i = NUM_FWD; i > 0; i--) begin
         if (hit_a[i-1]) sel_a = SEL_W'(i);
         if (hit_b[i-1]) sel_b = SEL_W'(i);
      end
   end

   assign forward_a = rst ? '0 : sel_a;
   assign forward_b = rst ? '0 : sel_b;

   // ---------------- Hazard detection ----------------
   logic lu_haz, sb_haz;
   logic busy_rs1, busy_rs2, busy_rd;
   logic sb_set;

   assign lu_haz = ex_mem_read && (ex_rd != X0) &&
                   ((id_use_rs1 && (ex_rd == id_rs1)) ||
                    (id_use_rs2 && (ex_rd == id_rs2)));

   assign sb_haz = (busy_rs1 && id_use_rs1) ||
                   (busy_rs2 && id_use_rs2) ||
                   (busy_rd  && id_reg_write);

   // A long-latency op held in ID has not issued yet, so it must not mark its rd.
   assign sb_set = lat_issue && (lat_rd != X0) && !stall_id;

   hazard_ctrl_unit_scoreboard #(
      .REG_AW (REG_AW)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .set_i    (sb_set),
      .set_rd_i (lat_rd),
      .clr_i    (lat_done),
      .clr_rd_i (lat_done_rd),
      .rd_a_i   (id_rs1),
      .rd_b_i   (id_rs2),
      .rd_w_i   (id_rd),
      .busy_a_o (busy_rs1),
      .busy_b_o (busy_rs2),
      .busy_w_o (busy_rd)
   );

   // ---------------- Arbitration FSM ----------------
   hz_state_e state_q, state_d;

   // Winner selection: mem wait > redirect > load-use > scoreboard; outputs forced low in reset.
   always_comb begin
      state_d         = ST_RUN;
      stall_if        = 1'b0;
      stall_id        = 1'b0;
      stall_ex_mem_wb = 1'b0;
      bubble_ex       = 1'b0;
      flush_if        = 1'b0;
      flush_id        = 1'b0;
      if (!rst) begin
         if (mem_busy) begin
            state_d         = ST_MEM_WAIT;
            stall_if        = 1'b1;
            stall_id        = 1'b1;
            stall_ex_mem_wb = 1'b1;
         end else if (ex_redirect) begin
            flush_if = 1'b1;
            flush_id = 1'b1;
         end else if (lu_haz) begin
            state_d   = ST_LU_STALL;
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
         end else if (sb_haz) begin
            state_d   = ST_SB_STALL;
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
         end
      end
   end

   // State register records last cycle's winning hazard class.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_RUN;
      else     state_q <= state_d;
   end

   // ---------------- Stall-cycle counter ----------------
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Saturating increment on every cycle the front end is held.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_if && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   // Counter register; only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall_cnt_q <= '0;
      else     stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cycles = stall_cnt_q;

   // Any non-RUN state follows a stalled cycle, so the counter cannot still be zero.
   always_ff @(posedge clk) begin
      if (!rst) assert (state_q == ST_RUN || stall_cnt_q != '0);
   end

endmodule
